// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared width defaults and packer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEFAULT_WIDTH      = 32;
    localparam int c_DEFAULT_BYTE_WIDTH = 8;
    localparam int c_DEFAULT_LANES      = c_DEFAULT_WIDTH / c_DEFAULT_BYTE_WIDTH;

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_PARTIAL = 1'b1
    } pack_state_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs byte symbols into WIDTH-bit words with keep/last.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH      = c_DEFAULT_WIDTH,
    parameter int BYTE_WIDTH = c_DEFAULT_BYTE_WIDTH,
    localparam int LANES     = WIDTH / BYTE_WIDTH,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clock,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LANES-1:0]      out_keep,
    output logic                  out_last
);

    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] c_LANE_ONE  = LANE_W'(1);

    pack_state_e       r_state;
    logic [LANE_W-1:0] r_lane_idx;
    logic [WIDTH-1:0]  r_acc;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [LANES-1:0]  r_out_keep;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_close;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  w_word;
    logic [LANES-1:0]  w_keep;

    // The output slot frees itself in the same cycle it drains, so no bubble.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_close    = w_accept && ((r_lane_idx == c_LAST_LANE) || in_last);

    // An EMPTY accumulator contributes nothing, so unfilled lanes read as zero.
    always_comb begin
        w_base = (r_state == ST_PARTIAL) ? r_acc : '0;
        w_word = w_base;
        w_word[r_lane_idx*BYTE_WIDTH +: BYTE_WIDTH] = in_data;
        w_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            w_keep[i] = (i <= int'(r_lane_idx));
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            r_state     <= ST_EMPTY;
            r_lane_idx  <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_state    <= ST_EMPTY;
                    r_lane_idx <= '0;
                    r_acc      <= '0;
                end else begin
                    r_state    <= ST_PARTIAL;
                    r_lane_idx <= r_lane_idx + c_LANE_ONE;
                    r_acc      <= w_word;
                end
            end

            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_keep  <= w_keep;
                r_out_last  <= in_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

endmodule : byte_packer
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_packer
// Description : Directed and random checks of byte_packer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_packer;

    localparam int c_W     = 32;
    localparam int c_BW    = 8;
    localparam int c_LANES = c_W / c_BW;

    logic             clock = 1'b0;
    logic             areset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [c_BW-1:0]  in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [c_W-1:0]   out_data;
    logic [c_LANES-1:0] out_keep;
    logic             out_last;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes of the open word, and the pending output word.
    logic [c_BW-1:0]    part_q[$];
    logic               exp_valid;
    logic [c_W-1:0]     exp_data;
    logic [c_LANES-1:0] exp_keep;
    logic               exp_last;
    // Words seen leaving the DUT: {keep, last, data}.
    logic [c_LANES+c_W:0] got_q[$];

    byte_packer #(.WIDTH(c_W), .BYTE_WIDTH(c_BW)) dut (
        .clock     (clock),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        part_q.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_keep  = '0;
        exp_last  = 1'b0;
    endtask

    // One clock: drive inputs, check mid-cycle against the model, advance model.
    task automatic cycle(input logic v, input logic [c_BW-1:0] d, input logic l, input logic r);
        logic exp_ready;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #3;
        exp_ready = !exp_valid || r;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_data", 64'(out_data), 64'(exp_data));
            chk("out_keep", 64'(out_keep), 64'(exp_keep));
            chk("out_last", 64'(out_last), 64'(exp_last));
        end
        if (out_valid && r) got_q.push_back({out_keep, out_last, out_data});
        if (exp_valid && r) exp_valid = 1'b0;
        if (v && exp_ready) begin
            part_q.push_back(d);
            if (l || part_q.size() == c_LANES) begin
                exp_data = '0;
                foreach (part_q[i]) exp_data = exp_data | (c_W'(part_q[i]) << (c_BW * i));
                exp_keep  = c_LANES'((1 << part_q.size()) - 1);
                exp_last  = l;
                exp_valid = 1'b1;
                part_q.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        in_valid = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(posedge clock);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        model_clear();
        @(posedge clock);
        #1;

        // Reset state, then idle with no output
        do_reset();
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Full word of four bytes
        got_q.delete();
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        cycle(1'b1, 8'h33, 1'b0, 1'b1);
        cycle(1'b1, 8'h44, 1'b0, 1'b1);
        chk("full_data", 64'(out_data), 64'h44332211);
        chk("full_keep", 64'(out_keep), 64'hF);
        chk("full_last", 64'(out_last), 64'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Partial word closed by in_last, then back-pressure with ignored input
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        chk("part_data", 64'(out_data), 64'h0000BBAA);
        chk("part_keep", 64'(out_keep), 64'h3);
        chk("part_last", 64'(out_last), 64'd1);
        repeat (3) cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_data", 64'(out_data), 64'h0000BBAA);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drained", 64'(out_valid), 64'd0);

        // Single byte with in_last on lane 0
        cycle(1'b1, 8'h5A, 1'b1, 1'b1);
        chk("lane0_keep", 64'(out_keep), 64'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back stream of eight bytes
        got_q.delete();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stream_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("stream_w0", 64'(got_q[0][c_W-1:0]), 64'h04030201);
            chk("stream_w1", 64'(got_q[1][c_W-1:0]), 64'h08070605);
        end

        // Reset mid-word discards the two held bytes
        cycle(1'b1, 8'hE0, 1'b0, 1'b1);
        cycle(1'b1, 8'hE1, 1'b0, 1'b1);
        do_reset();
        got_q.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_word_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            chk("rst_word_data", 64'(got_q[0][c_W-1:0]), 64'h13121110);
            chk("rst_word_keep", 64'(got_q[0][c_LANES+c_W:c_W+1]), 64'hF);
        end

        // Random traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) < 7));
        end
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_byte_packer
`default_nettype wire
